// File: rtl/posit_encoder_pipe.sv
// posit<64,4> field encoder: packs sign/regime/exponent/fraction into a posit word
// with round-to-nearest-even, as a 3-stage valid/ready pipeline with full backpressure.
module posit_encoder_pipe #(
  parameter int NBITS = 64,
  parameter int ES    = 4,
  parameter int FBITS = NBITS - ES - 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [6:0]       in_regi,
  input  logic [ES-1:0]    in_expo,
  input  logic [FBITS-1:0] in_frac,
  input  logic             in_guard,
  input  logic             in_sticky,
  input  logic             in_zero,
  input  logic             in_nar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_posit
);

  localparam int BODYW = NBITS - 1;        // magnitude bits below the sign
  localparam int TAILW = ES + FBITS + 1;   // exponent, fraction and guard
  localparam int WIDEW = 2 * NBITS;        // room for the longest regime plus the full tail
  localparam int PADW  = WIDEW - 1 - TAILW;

  typedef enum logic [2:0] {
    CLS_NORMAL,
    CLS_SAT_MAX,
    CLS_SAT_MIN,
    CLS_ZERO,
    CLS_NAR
  } cls_e;

  // Pipeline registers
  logic               s1_valid_q, s2_valid_q, s3_valid_q;
  cls_e               s1_cls_q, s2_cls_q;
  logic               s1_sign_q, s2_sign_q;
  logic               s1_neg_q;
  logic [5:0]         s1_shamt_q;
  logic [TAILW-1:0]   s1_tail_q;
  logic               s1_sticky_q;
  logic [BODYW-1:0]   s2_body_q;
  logic [NBITS-1:0]   out_posit_q;

  // Combinational next-state values
  cls_e               s1_cls_d;
  logic signed [7:0]  regi_s;
  logic [7:0]         run_d;
  logic               neg_d;
  logic [WIDEW-1:0]   regime_bits, wide;
  logic [BODYW-1:0]   body_raw, body_d;
  logic               rnd_l, rnd_g, rnd_s;
  logic [NBITS-1:0]   rnd_sum;
  logic [NBITS-1:0]   mag, posit_d;

  logic advance;

  // Every stage moves together; only a full output stage that is not being drained stalls.
  assign advance   = !(s3_valid_q && !out_ready);
  assign in_ready  = advance;
  assign out_valid = s3_valid_q;
  assign out_posit = out_posit_q;

  // ---------------- Stage 1: classify, regime run length ----------------
  // Sign-extend to 8 bits so -(-64) and 63+1 do not wrap.
  assign regi_s = {in_regi[6], in_regi};
  assign neg_d  = regi_s[7];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    run_d    = neg_d ? 8'(-regi_s) : 8'(regi_s + 8'sd1);
    s1_cls_d = CLS_NORMAL;
    if (in_nar)               s1_cls_d = CLS_NAR;
    else if (in_zero)         s1_cls_d = CLS_ZERO;
    else if (run_d >= 8'd63)  s1_cls_d = neg_d ? CLS_SAT_MIN : CLS_SAT_MAX;
  end

  // ---------------- Stage 2: assemble and round ----------------
  // Regime occupies the top (shamt+1) bits of the wide vector; the tail follows it.
  always_comb begin
    regime_bits = s1_neg_q ? ({1'b1, {(WIDEW-1){1'b0}}} >> s1_shamt_q)
                           : ~({WIDEW{1'b1}} >> s1_shamt_q);
    wide        = regime_bits | ({1'b0, s1_tail_q, {PADW{1'b0}}} >> s1_shamt_q);
    body_raw    = wide[WIDEW-1 -: BODYW];
    rnd_l       = wide[WIDEW-BODYW];
    rnd_g       = wide[WIDEW-BODYW-1];
    rnd_s       = (|wide[WIDEW-BODYW-2:0]) | s1_sticky_q;
    rnd_sum     = {1'b0, body_raw} + {{(NBITS-1){1'b0}}, rnd_g & (rnd_l | rnd_s)};
    body_d      = rnd_sum[NBITS-1] ? {BODYW{1'b1}} : rnd_sum[BODYW-1:0];
    if (body_d == '0) body_d = {{(BODYW-1){1'b0}}, 1'b1};
  end

  // ---------------- Stage 3: saturation, sign, specials ----------------
  always_comb begin
    mag = {1'b0, s2_body_q};
    case (s2_cls_q)
      CLS_SAT_MAX: mag = {1'b0, {BODYW{1'b1}}};
      CLS_SAT_MIN: mag = {{(NBITS-1){1'b0}}, 1'b1};
      default:     mag = {1'b0, s2_body_q};
    endcase
    posit_d = s2_sign_q ? (~mag + 1'b1) : mag;
    if (s2_cls_q == CLS_ZERO) posit_d = '0;
    if (s2_cls_q == CLS_NAR)  posit_d = {1'b1, {(NBITS-1){1'b0}}};
  end

  // NOTE: only the valid bits and the visible output word need a reset value; the
  // datapath registers behind them are qualified by valid and are left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_posit_q <= '0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      if (s2_valid_q) out_posit_q <= posit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_cls_q    <= s1_cls_d;
      s1_sign_q   <= in_sign;
      s1_neg_q    <= neg_d;
      s1_shamt_q  <= run_d[5:0];
      s1_tail_q   <= {in_expo, in_frac, in_guard};
      s1_sticky_q <= in_sticky;
    end
    if (advance && s1_valid_q) begin
      s2_cls_q  <= s1_cls_q;
      s2_sign_q <= s1_sign_q;
      s2_body_q <= body_d;
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Directed bench for posit_encoder_pipe: hand-computed encodings, rounding ties,
// saturation/special codes, backpressure ordering/stability and mid-stream reset.
module tb_posit_encoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [6:0]  in_regi = '0;
  logic [3:0]  in_expo = '0;
  logic [56:0] in_frac = '0;
  logic        in_guard = 1'b0;
  logic        in_sticky = 1'b0;
  logic        in_zero = 1'b0;
  logic        in_nar = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_posit;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  posit_encoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_regi   (in_regi),
    .in_expo   (in_expo),
    .in_frac   (in_frac),
    .in_guard  (in_guard),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sign, input logic [6:0] regi, input logic [3:0] expo,
                       input logic [56:0] frac, input logic guard, input logic sticky,
                       input logic zero, input logic nar);
    in_sign   = sign;
    in_regi   = regi;
    in_expo   = expo;
    in_frac   = frac;
    in_guard  = guard;
    in_sticky = sticky;
    in_zero   = zero;
    in_nar    = nar;
  endtask

  // Single transfer, then wait (bounded) for the result and check latency and value.
  task automatic send_one(input string tag, input logic sign, input logic [6:0] regi,
                          input logic [3:0] expo, input logic [56:0] frac, input logic guard,
                          input logic sticky, input logic zero, input logic nar,
                          input logic [63:0] exp);
    int lat;
    drive(sign, regi, expo, frac, guard, sticky, zero, nar);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd3);
    check(tag, out_posit, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recvd;
    logic [63:0] held;

    // Reset state, asynchronous while rst_n is low
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_posit", out_posit, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", 64'(in_ready), 64'd1);
    check("post-reset out_valid", 64'(out_valid), 64'd0);

    // Basic encodings
    send_one("r0 pos",     1'b0, 7'd0,  4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000);
    send_one("r0 neg",     1'b1, 7'd0,  4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hC000_0000_0000_0000);
    send_one("r1 e3",      1'b0, 7'd1,  4'd3, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h6300_0000_0000_0000);
    send_one("r1 e3 neg",  1'b1, 7'd1,  4'd3, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h9D00_0000_0000_0000);
    send_one("rm1",        1'b0, 7'h7F, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2000_0000_0000_0000);
    send_one("r2 e5 fmsb", 1'b0, 7'd2,  4'd5, 57'h100_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0,
             64'h72C0_0000_0000_0000);

    // Rounding at full-width tail (nothing dropped, guard is G)
    send_one("rnd carry",  1'b0, 7'd0,  4'd0, {57{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4200_0000_0000_0000);
    send_one("tie even",   1'b0, 7'd0,  4'd0, 57'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0000);
    send_one("tie odd",    1'b0, 7'd0,  4'd0, 57'd1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h4000_0000_0000_0002);
    send_one("tie odd neg",1'b1, 7'd0,  4'd0, 57'd1, 1'b1, 1'b0, 1'b0, 1'b0, 64'hBFFF_FFFF_FFFF_FFFE);
    // Rounding with dropped fraction bits (regime length 4 drops two fraction bits)
    send_one("drop tie",   1'b0, 7'd2,  4'd5, 57'd2, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7280_0000_0000_0000);
    send_one("drop sticky",1'b0, 7'd2,  4'd5, 57'd2, 1'b0, 1'b1, 1'b0, 1'b0, 64'h7280_0000_0000_0001);

    // Regime boundaries
    send_one("r61",        1'b0, 7'h3D, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFE);
    send_one("r61 tie",    1'b0, 7'h3D, 4'd8, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFE);
    send_one("r61 up",     1'b0, 7'h3D, 4'd9, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
    send_one("rm62",       1'b0, 7'h42, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
    send_one("rm62 tie",   1'b0, 7'h42, 4'd8, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0002);
    send_one("sat r62",    1'b0, 7'h3E, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
    send_one("sat r63",    1'b0, 7'h3F, 4'd7, 57'd5, 1'b1, 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
    send_one("sat r63 neg",1'b1, 7'h3F, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0001);
    send_one("sat rm63",   1'b0, 7'h41, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
    send_one("sat rm64",   1'b0, 7'h40, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
    send_one("sat rm64 neg",1'b1,7'h40, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Specials
    send_one("zero",       1'b1, 7'd5,  4'd3, 57'd9, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0000);
    send_one("nar+zero",   1'b0, 7'd0,  4'd0, 57'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
    send_one("nar neg",    1'b1, 7'h3F, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000_0000_0000);

    // Backpressure: 8 back-to-back words, out_ready low for cycles 6..10
    @(posedge clk); #1;
    sent  = 0;
    recvd = 0;
    held  = '0;
    for (int cyc = 0; cyc < 60 && recvd < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 10);
      in_valid  = (sent < 8);
      drive(1'b0, 7'd0, 4'd0, 57'(sent), 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (out_valid && !out_ready) begin
        check("bp in_ready low", 64'(in_ready), 64'd0);
        if (cyc > 6) check("bp stable", out_posit, held);
        held = out_posit;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp word %0d", recvd), out_posit, 64'h4000_0000_0000_0000 | 64'(recvd));
        recvd++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp all sent", 64'(sent), 64'd8);
    check("bp all received", 64'(recvd), 64'd8);

    // Reset with three words in flight
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'd0, 4'd0, 57'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("flight out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset out_posit", out_posit, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", 64'(in_ready), 64'd1);
    check("release out_valid", 64'(out_valid), 64'd0);
    send_one("after reset", 1'b0, 7'h7F, 4'd0, 57'd0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h2000_0000_0000_0000);
    @(posedge clk); #1;
    check("drained out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
